dcache_mem_ctrl: RTL and testbench

- Line-transfer engine between the direct-mapped data cache and word-wide main memory.
- Accepts one whole-line request at a time from the cache:
  - write-back of a dirty victim line, or
  - fill of a missing line.
- Serialises each request into 16 single-word memory accesses. For a fill, reassembles the returned words into one line and hands it back.
- Removes all bulk line copying from the cache's own clocked logic.

---
 rtl/dcache_pkg.sv | 25 ++
 rtl/dcache_mem_ctrl_if.sv | 33 +++
 rtl/dcache_rd_lat_pipe.sv | 32 +++
 rtl/dcache_mem_ctrl.sv | 147 ++++++++++++++
 tb/tb_dcache_mem_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_pkg.sv
// Address split, line packing and engine state shared by the data cache
// and its line-transfer engine.
package dcache_pkg;

    localparam int ADDR_W  = 17;
    localparam int DATA_W  = 32;
    localparam int WORDS   = 16;
    localparam int OFF_W   = $clog2(WORDS);
    localparam int TAG_W   = 3;
    localparam int IDX_W   = 10;
    localparam int LADDR_W = TAG_W + IDX_W;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ISSUE,
        RD_DRAIN,
        RESP
    } state_e;

    typedef logic [WORDS-1:0][DATA_W-1:0] line_t;
    typedef logic [OFF_W-1:0]             beat_t;
    typedef logic [LADDR_W-1:0]           laddr_t;

endpackage

// File: rtl/dcache_mem_ctrl_if.sv
// Cache-side line handshake plus the word-wide memory port.
interface dcache_mem_ctrl_if;
    import dcache_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    laddr_t            req_laddr;
    line_t             req_wline;
    logic              resp_valid;
    logic              resp_ready;
    line_t             resp_rline;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output req_valid, req_wr, req_laddr, req_wline,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rline,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_wr, req_laddr, req_wline,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rline,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dcache_rd_lat_pipe.sv
// Valid shift register tracking outstanding reads; its output marks the
// cycle in which mem_rdata belongs to the oldest issued read.
module dcache_rd_lat_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_i,
    output logic valid_o
);

    logic [DEPTH-1:0] pipe_q, pipe_d;

    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = push_i;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign valid_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/dcache_mem_ctrl.sv
// Line-transfer engine: serialises one cache line request into WORDS
// single-word memory accesses and reassembles fills.
module dcache_mem_ctrl
    import dcache_pkg::*;
#(
    parameter int MEM_RD_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    dcache_mem_ctrl_if.slave bus
);

    state_e            state_q, state_d;
    beat_t             beat_q, beat_d;
    beat_t             cap_q, cap_d;
    beat_t             beat_nx;
    laddr_t            laddr_q, laddr_d;
    line_t             wline_q, wline_d;
    line_t             rline_q, rline_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              rd_vld;

    dcache_rd_lat_pipe #(
        .DEPTH (MEM_RD_LAT)
    ) u_rd_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (mem_en_q & ~mem_we_q),
        .valid_o (rd_vld)
    );

    assign beat_nx = beat_q + beat_t'(1);

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        cap_d        = cap_q;
        laddr_d      = laddr_q;
        wline_d      = wline_q;
        rline_d      = rline_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        // Returned words arrive in issue order, so a running index suffices.
        if (rd_vld && (state_q == RD_ISSUE || state_q == RD_DRAIN)) begin
            rline_d[cap_q] = bus.mem_rdata;
            cap_d          = cap_q + beat_t'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    laddr_d     = bus.req_laddr;
                    wline_d     = bus.req_wline;
                    req_ready_d = 1'b0;
                    beat_d      = '0;
                    cap_d       = '0;
                    mem_en_d    = 1'b1;
                    mem_we_d    = bus.req_wr;
                    mem_addr_d  = {bus.req_laddr, beat_t'(0)};
                    mem_wdata_d = bus.req_wr ? bus.req_wline[0] : '0;
                    state_d     = bus.req_wr ? WR : RD_ISSUE;
                end
            end
            WR, RD_ISSUE: begin
                if (beat_q == beat_t'(WORDS - 1)) begin
                    if (state_q == WR) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                    end else begin
                        state_d = RD_DRAIN;
                    end
                end else begin
                    beat_d     = beat_nx;
                    mem_en_d   = 1'b1;
                    mem_we_d   = (state_q == WR);
                    mem_addr_d = {laddr_q, beat_nx};
                    if (state_q == WR) begin
                        mem_wdata_d = wline_q[beat_nx];
                    end
                end
            end
            RD_DRAIN: begin
                if (rd_vld && cap_q == beat_t'(WORDS - 1)) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            cap_q        <= '0;
            laddr_q      <= '0;
            wline_q      <= '0;
            rline_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            cap_q        <= cap_d;
            laddr_q      <= laddr_d;
            wline_q      <= wline_d;
            rline_q      <= rline_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rline = rline_q;
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_dcache_mem_ctrl.sv
// Bench for dcache_mem_ctrl: three engines with read latencies 2, 1 and 8
// share one stimulus bus; only the selected engine sees req_valid.
module tb_dcache_mem_ctrl;
    import dcache_pkg::*;

    logic   clk = 1'b0;
    logic   rst_n;
    int     sel;
    logic   req_valid, req_wr, resp_ready;
    laddr_t req_laddr;
    line_t  req_wline;

    logic [2:0]        rr, rv, men, mwe;
    logic [ADDR_W-1:0] ma [3];
    logic [DATA_W-1:0] mwd [3];
    line_t             rl [3];

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 8);
        dcache_mem_ctrl_if bus ();
        logic [DATA_W-1:0] dl [LAT];

        assign bus.req_valid  = req_valid & (sel == g);
        assign bus.req_wr     = req_wr;
        assign bus.req_laddr  = req_laddr;
        assign bus.req_wline  = req_wline;
        assign bus.resp_ready = resp_ready;
        assign bus.mem_rdata  = dl[LAT-1];

        // Memory returns word (addr ^ 5A5A5A5A) exactly LAT cycles after issue.
        always @(posedge clk) begin
            dl[0] <= {15'b0, bus.mem_addr} ^ 32'h5A5A_5A5A;
            for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
        end

        dcache_mem_ctrl #(
            .MEM_RD_LAT (LAT)
        ) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave)
        );

        assign rr[g]  = bus.req_ready;
        assign rv[g]  = bus.resp_valid;
        assign men[g] = bus.mem_en;
        assign mwe[g] = bus.mem_we;
        assign ma[g]  = bus.mem_addr;
        assign mwd[g] = bus.mem_wdata;
        assign rl[g]  = bus.resp_rline;
    end

    typedef struct {
        int     k;
        bit     wr;
        laddr_t la;
        line_t  wl;
        int     exp_c;
        int     hold;
        bit     poke;
    } vec_t;

    vec_t tbl[$];

    function automatic int lat_of(int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 8);
    endfunction

    function automatic line_t fill_of(laddr_t la);
        line_t l;
        for (int i = 0; i < WORDS; i++) begin
            l[i] = {15'b0, la, 4'(i)} ^ 32'h5A5A_5A5A;
        end
        return l;
    endfunction

    function automatic line_t rand_line();
        line_t l;
        for (int i = 0; i < WORDS; i++) l[i] = $urandom;
        return l;
    endfunction

    task automatic chk(input string nm, input logic [511:0] act,
                       input logic [511:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic do_req(input int k, input bit wr, input laddr_t la,
                          input line_t wl, input int exp_c,
                          input int hold, input bit poke);
        line_t prev;
        int    to;
        to = 0;
        while (!rr[k] && to < 100) begin
            @(negedge clk);
            to++;
        end
        chk("wait_ready", rr[k], 1'b1);
        prev      = rl[k];
        sel       = k;
        req_valid = 1'b1;
        req_wr    = wr;
        req_laddr = la;
        req_wline = wl;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_laddr = ~la;
        req_wline = ~wl;
        for (int c = 1; c <= exp_c; c++) begin
            if (poke && c == 5) begin
                req_valid = 1'b1;
                req_wr    = 1'b0;
                req_laddr = 13'h0123;
            end
            if (poke && c == 6) req_valid = 1'b0;
            chk("burst_en", men[k], c <= WORDS);
            if (c <= WORDS) begin
                chk("burst_we", mwe[k], wr);
                chk("burst_addr", ma[k], {la, 4'(c - 1)});
                if (wr) chk("burst_wdata", mwd[k], wl[c-1]);
            end
            chk("busy_rdy", rr[k], 1'b0);
            chk("resp_timing", rv[k], c == exp_c);
            if (c < exp_c) @(negedge clk);
        end
        if (!wr) chk("fill_line", rl[k], fill_of(la));
        else     chk("wb_keep_line", rl[k], prev);
        prev = rl[k];
        if (poke) begin
            req_valid = 1'b1;
            req_wr    = 1'b0;
            req_laddr = 13'h0123;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_rv", rv[k], 1'b1);
            chk("hold_rdy", rr[k], 1'b0);
            chk("hold_en", men[k], 1'b0);
            chk("hold_line", rl[k], prev);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("post_rv", rv[k], 1'b0);
        chk("post_rdy", rr[k], 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t  v;
        line_t wb;
        rst_n      = 1'b0;
        sel        = 0;
        req_valid  = 1'b0;
        req_wr     = 1'b0;
        req_laddr  = '0;
        req_wline  = '0;
        resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_addr", ma[k], '0);
            chk("rst_wdata", mwd[k], '0);
            chk("rst_line", rl[k], '0);
            chk("rst_we", mwe[k], 1'b0);
        end
        for (int c = 0; c < 5; c++) begin
            for (int k = 0; k < 3; k++) begin
                chk("idle_rdy", rr[k], 1'b1);
                chk("idle_rv", rv[k], 1'b0);
                chk("idle_en", men[k], 1'b0);
            end
            @(negedge clk);
        end

        for (int i = 0; i < WORDS; i++) wb[i] = 32'hA000_0000 + i;
        tbl.push_back('{0, 1'b1, 13'h00A5, wb, 17, 2, 1'b1});
        tbl.push_back('{0, 1'b0, 13'h0123, rand_line(), 19, 0, 1'b0});
        tbl.push_back('{0, 1'b0, 13'h1FFF, rand_line(), 19, 1, 1'b0});
        tbl.push_back('{1, 1'b0, 13'h1FFF, rand_line(), 18, 0, 1'b0});
        tbl.push_back('{2, 1'b0, 13'h1FFF, rand_line(), 25, 2, 1'b0});
        tbl.push_back('{1, 1'b1, 13'h1FFF, rand_line(), 17, 0, 1'b0});
        foreach (tbl[i]) begin
            v = tbl[i];
            do_req(v.k, v.wr, v.la, v.wl, v.exp_c, v.hold, v.poke);
        end

        sel       = 0;
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_laddr = 13'h0777;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (7) @(negedge clk);
        chk("abort_beat7", ma[0], {13'h0777, 4'd7});
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_en", men[0], 1'b0);
        chk("abort_rdy", rr[0], 1'b1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("abort_no_rv", rv[0], 1'b0);
            chk("abort_no_en", men[0], 1'b0);
        end
        do_req(0, 1'b0, 13'h0777, rand_line(), 19, 0, 1'b0);

        for (int n = 0; n < 12; n++) begin
            v.k     = $urandom_range(0, 2);
            v.wr    = 1'($urandom_range(0, 1));
            v.la    = laddr_t'($urandom);
            v.wl    = rand_line();
            v.exp_c = v.wr ? 17 : 17 + lat_of(v.k);
            v.hold  = $urandom_range(0, 3);
            do_req(v.k, v.wr, v.la, v.wl, v.exp_c, v.hold, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
